// File: rtl/enigma_text_feeder.sv
// enigma_text_feeder
//   Input stage for the three-rotor cipher core. Takes ASCII characters over a
//   valid/ready handshake and keeps only letters, mapped to codes 1..26. It
//   buffers them in a small circular FIFO and issues them one at a time on
//   symb_o. After each symbol, GAP idle cycles are forced.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   GAP    idle cycles forced after each issued symbol (0..15)
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous, active-low reset
//   ascii_i        input character
//   ascii_valid_i  ascii_i valid this cycle
//   ascii_ready_o  feeder can take a character (FIFO not full)
//   en_i           issue enable; intake continues while low
//   symb_o         letter code to core (1..26), 0 = no symbol
//   symb_valid_o   high exactly when symb_o != 0
//   level_o        FIFO occupancy, 0..DEPTH
//   drop_cnt_o     rejected-character count, saturating at 255
//   busy_o         FIFO non-empty, FSM not idle, or a symbol on symb_o
module enigma_text_feeder #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               ascii_i,
    input  logic                     ascii_valid_i,
    output logic                     ascii_ready_o,
    input  logic                     en_i,
    output logic [6:0]               symb_o,
    output logic                     symb_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [7:0]               drop_cnt_o,
    output logic                     busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0]    GAP_L   = 4'(GAP);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      gap_cnt_reg, gap_cnt_next;
    logic [6:0]      symb_reg, symb_next;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic [7:0]      drop_reg;
    logic [4:0]      mem [DEPTH];

    logic            xfer, is_letter, push, pop;
    logic [4:0]      letter_code;

    // Ready depends on occupancy only, never on the character or a same-cycle pop.
    assign ascii_ready_o = (level_reg != DEPTH_L);
    assign xfer          = ascii_valid_i && ascii_ready_o;

    // 'A'..'Z' and 'a'..'z' both carry their alphabet index in the low five bits.
    assign is_letter   = ((ascii_i >= 8'h41) && (ascii_i <= 8'h5A)) ||
                         ((ascii_i >= 8'h61) && (ascii_i <= 8'h7A));
    assign letter_code = ascii_i[4:0];
    assign push        = xfer && is_letter;

    // FIFO storage: no reset, so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= letter_code;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            drop_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (xfer && !is_letter && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

    // Issue FSM: state register.
    // The symbol register is reset asynchronously, so a reset clears any
    // in-flight symbol at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= S_IDLE;
            gap_cnt_reg <= '0;
            symb_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            symb_reg    <= symb_next;
        end
    end

    // Issue FSM: next state.
    // WAIT always runs to completion; en_i is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (en_i && (level_reg != '0) && (GAP_L != 4'd0)) state_next = S_WAIT;
            S_WAIT: if (gap_cnt_reg == 4'd1) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Issue FSM: outputs.
    // The pop decision uses occupancy before the edge, so a letter pushed on
    // this edge is not issued until the next one.
    always_comb begin
        pop          = 1'b0;
        symb_next    = '0;
        gap_cnt_next = gap_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (en_i && (level_reg != '0)) begin
                    pop          = 1'b1;
                    symb_next    = {2'b00, mem[rd_ptr_reg]};
                    gap_cnt_next = GAP_L;
                end
            end
            S_WAIT: gap_cnt_next = gap_cnt_reg - 4'd1;
            default: gap_cnt_next = '0;
        endcase
    end

    assign symb_o       = symb_reg;
    assign symb_valid_o = (symb_reg != '0);
    assign level_o      = level_reg;
    assign drop_cnt_o   = drop_reg;
    assign busy_o       = (level_reg != '0) || (state_reg != S_IDLE) || (symb_reg != '0);

endmodule

// File: tb/tb_enigma_text_feeder.sv
// Testbench for enigma_text_feeder.
// Directed steps and a random phase. Every cycle is compared against a
// queue-based reference model of the feeder.
module tb_enigma_text_feeder;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    ascii_i;
    logic          ascii_valid_i;
    logic          ascii_ready_o;
    logic          en_i;
    logic [6:0]    symb_o;
    logic          symb_valid_o;
    logic [LW-1:0] level_o;
    logic [7:0]    drop_cnt_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q[$];     // buffered letter codes, head first
    int m_cool;     // idle cycles still owed after the last symbol
    int m_symb;     // symbol currently on the output
    int m_drop;

    enigma_text_feeder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ascii_i       (ascii_i),
        .ascii_valid_i (ascii_valid_i),
        .ascii_ready_o (ascii_ready_o),
        .en_i          (en_i),
        .symb_o        (symb_o),
        .symb_valid_o  (symb_valid_o),
        .level_o       (level_o),
        .drop_cnt_o    (drop_cnt_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int code_of(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) return int'(c) - 64;
        if (c >= 8'h61 && c <= 8'h7A) return int'(c) - 96;
        return 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cool = 0;
        m_symb = 0;
        m_drop = 0;
    endtask

    // One rising edge of the model, evaluated from the inputs held before the edge.
    task automatic model_edge();
        int  c;
        bit  room;
        room   = (m_q.size() < DEPTH);
        m_symb = 0;
        if (m_cool == 0 && en_i && m_q.size() > 0) begin
            m_symb = m_q.pop_front();
            m_cool = GAP;
        end else if (m_cool > 0) begin
            m_cool--;
        end
        if (ascii_valid_i && room) begin
            c = code_of(ascii_i);
            if (c != 0) m_q.push_back(c);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    task automatic check_all();
        chk("symb",       symb_o,        m_symb);
        chk("symb_valid", symb_valid_o,  m_symb != 0);
        chk("level",      level_o,       m_q.size());
        chk("drop",       drop_cnt_o,    m_drop);
        chk("ready",      ascii_ready_o, m_q.size() != DEPTH);
        chk("busy",       busy_o,        (m_q.size() > 0) || (m_cool > 0) || (m_symb != 0));
    endtask

    // Drive inputs, advance one clock, update the model and compare 1 time unit later.
    task automatic cyc(input logic v, input logic [7:0] c, input logic e);
        ascii_valid_i = v;
        ascii_i       = c;
        en_i          = e;
        @(posedge clk_i);
        if (rst_i) model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] bad [6];
        logic [7:0] ch;
        bad[0] = "3"; bad[1] = " "; bad[2] = "@";
        bad[3] = "["; bad[4] = 8'h60; bad[5] = "{";

        // Reset state
        rst_i = 1'b0; ascii_i = '0; ascii_valid_i = 1'b0; en_i = 1'b1;
        model_reset();
        #1;
        check_all();
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        rst_i = 1'b1;

        // 'A','b','Z' with GAP=1 gives 1,0,2,0,26
        cyc(1, "A", 1);
        cyc(1, "b", 1);
        cyc(1, "Z", 1);
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);

        // Non-letters around the letter ranges are dropped; only 'c' is issued.
        for (int i = 0; i < 6; i++) cyc(1, bad[i], 1);
        cyc(1, "c", 1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);
        chk("drop_after_nonletters", drop_cnt_o, 6);

        // Fill with issuing paused; the fifth letter is refused while full.
        cyc(1, "K", 0);
        cyc(1, "L", 0);
        cyc(1, "M", 0);
        cyc(1, "N", 0);
        chk("full_level", level_o, DEPTH);
        cyc(1, "O", 0);
        chk("full_not_ready", ascii_ready_o, 0);
        // The source holds 'O' until ready returns.
        for (int i = 0; i < 14; i++) begin
            if (ascii_ready_o) break;
            cyc(1, "O", 1);
        end
        cyc(1, "O", 1);
        for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1);

        // Reset mid-operation with level 3 and symbol 7 ('G') on the output.
        cyc(1, "G", 0);
        cyc(1, "H", 0);
        cyc(1, "I", 0);
        cyc(1, "J", 0);
        cyc(0, 8'h00, 1);
        chk("pre_reset_symb",  symb_o,  7);
        chk("pre_reset_level", level_o, 3);
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        chk("rst_symb",  symb_o,        0);
        chk("rst_valid", symb_valid_o,  0);
        chk("rst_level", level_o,       0);
        chk("rst_drop",  drop_cnt_o,    0);
        chk("rst_ready", ascii_ready_o, 1);
        chk("rst_busy",  busy_o,        0);
        cyc(0, 8'h00, 1);
        rst_i = 1'b1;
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) != 0)
                ch = 8'($urandom_range(0, 25)) + (($urandom_range(0, 1) != 0) ? 8'h41 : 8'h61);
            else
                ch = 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 3) != 0, ch, $urandom_range(0, 7) != 0);
        end
        for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1);

        // The drop counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            ch = 8'($urandom_range(0, 63));
            cyc(1, ch, 1);
        end
        chk("drop_saturated", drop_cnt_o, 255);
        cyc(0, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enigma_text_feeder.md
# enigma_text_feeder

Upstream input stage for the three-rotor cipher core. Accepts 8-bit ASCII characters over a valid/ready handshake, maps letters to the core's serial letter code (A/a=1 … Z/z=26), discards everything else, buffers accepted letters in a small FIFO and issues them to the core's 7-bit symbol input one at a time. The core steps its rotors on every non-zero symbol, so the feeder drives exactly one non-zero symbol per issued letter and 0 on every other cycle.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- GAP, 1: idle cycles (symb_o=0) forced after each issued symbol; 0..15.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- ascii_i  in  8  input character.
- ascii_valid_i  in  1  ascii_i valid this cycle.
- ascii_ready_o  out  1  feeder can take a character this cycle.
- en_i  in  1  issue enable; low pauses issuing, intake continues.
- symb_o  out  7  letter code to core, 1..26; 0 = no symbol.
- symb_valid_o  out  1  high exactly when symb_o ≠ 0.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- drop_cnt_o  out  8  count of rejected characters, saturates at 255.
- busy_o  out  1  FIFO non-empty, or FSM not IDLE, or symb_o ≠ 0.

## Operation
- Transfer occurs on a rising edge where ascii_valid_i && ascii_ready_o.
- ascii_ready_o = (level_o != DEPTH), combinational from occupancy only; it does not depend on ascii_i or on a same-cycle pop. Full FIFO refuses all characters, letters or not.
- Mapping on transfer: 0x41–0x5A → ascii_i−0x40; 0x61–0x7A → ascii_i−0x60; pushed as a 5-bit entry. Any other value: not pushed, drop_cnt_o += 1 (holds at 255).
- FIFO: circular, read/write pointers wrap modulo DEPTH; level_o updated each edge by +push −pop.
- Issue FSM, states IDLE and WAIT; registered symb_o:
  - IDLE, en_i=1 and level_o>0: symb_o ← head entry (zero-extended), pop; gap_cnt ← GAP; next = WAIT if GAP>0 else IDLE.
  - IDLE otherwise: symb_o ← 0.
  - WAIT: symb_o ← 0; gap_cnt −1; when gap_cnt==1 next = IDLE. en_i is ignored in WAIT (gap always completes).
- Pop decision uses occupancy before the edge; a letter pushed on edge k is not visible to the FSM until after edge k.
- Push and pop on the same edge both take effect (level unchanged) whenever FIFO is neither full nor empty.
- Letter order preserved; no letter issued twice, none lost once accepted.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): FIFO empty, pointers 0, level_o=0, symb_o=0, symb_valid_o=0, drop_cnt_o=0, state IDLE, gap_cnt=0, ascii_ready_o=1, busy_o=0.
- Reset mid-operation: buffered letters discarded, any in-flight symbol cleared immediately; no partial symbol reaches the core.
- Latency: letter accepted on edge k into empty FIFO with en_i=1 and FSM IDLE → symb_o valid after edge k+1, for exactly one cycle.
- Throughput: one symbol per GAP+1 cycles; GAP=0 gives back-to-back symbols.
- en_i falling: takes effect at the next IDLE evaluation; a symbol already registered completes its single cycle.
- en_i rising with non-empty FIFO in IDLE: symbol after the next edge.

## Test plan
- Reset, then push 'A','b','Z' (GAP=1, en_i=1) → symb_o sequence 1,0,26,0,2? no: 1,0,2,0,26 with symb_valid_o high only on non-zero cycles; drop_cnt_o=0.
- Push '3',' ','@','[','`','{' then 'c' → only symb_o=3 issued; drop_cnt_o=6.
- en_i=0, push 5 letters with DEPTH=4 → 4 accepted, ascii_ready_o=0 with level_o=4, 5th held by source; raise en_i → 4 symbols issued in order, ready returns after first pop.
- GAP=0, FIFO pre-filled 'D','E','F', enable → symb_o=4,5,6 on consecutive cycles, then 0; busy_o falls the cycle after 6 leaves symb_o.
- Assert rst_i while level_o=3 and symb_o=7 → symb_o=0, level_o=0, drop_cnt_o=0 immediately; after release no stale letter appears.
- Push 300 non-letters → drop_cnt_o saturates at 255, no symbol issued.
